// File: rtl/bcd_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_serial_add_ctrl
//
// Adds two packed BCD operands one digit per cycle, least-significant digit
// first. It drives a single external combinational BCD digit adder and keeps
// the decimal carry between digits in a register. This lets one digit adder
// do the work of DIGITS parallel adders, at the cost of DIGITS+1 cycles per
// operation.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request; taken only while ready=1
//   a, b            packed BCD operands, digit 0 in [3:0]
//   ready           1 in IDLE and DONE (a start will be accepted)
//   busy            1 while digits are being added
//   done            one-cycle pulse; sum/cout/err are valid
//   sum, cout, err  result, decimal carry out, bad-digit flag (held)
//   dig_a, dig_b,
//   dig_cin         operands and carry presented to the shared digit adder
//   dig_s, dig_cout digit sum and carry returned by the shared digit adder
// -----------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic [3:0]            dig_a,
  output logic [3:0]            dig_b,
  output logic                  dig_cin,
  input  logic [3:0]            dig_s,
  input  logic                  dig_cout
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [W-1:0]     sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic             ops_ok;

  // True when every 4-bit digit of v is a legal BCD digit (0..9).
  function automatic logic digits_ok(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  assign ops_ok = digits_ok(a) && digits_ok(b);

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sum_d  = '0;
          cout_d = 1'b0;
          if (ops_ok) begin
            state_d  = S_ADD;
            a_sh_d   = a;
            b_sh_d   = b;
            sum_sh_d = '0;
            carry_d  = 1'b0;
            cnt_d    = '0;
            err_d    = 1'b0;
          end else begin
            // Bad digit: skip the adder entirely and report straight away.
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_ADD: begin
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        // Result digits enter at the top, so after DIGITS shifts digit 0
        // has reached [3:0].
        sum_sh_d = {dig_s, sum_sh_q[W-1:4]};
        carry_d  = dig_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          sum_d   = {dig_s, sum_sh_q[W-1:4]};
          cout_d  = dig_cout;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
    end
  end

  assign ready   = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy    = (state_q == S_ADD);
  assign done    = (state_q == S_DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign err     = err_q;

  // The shared adder sees zeros whenever this block is not using it.
  assign dig_a   = busy ? a_sh_q[3:0] : 4'd0;
  assign dig_b   = busy ? b_sh_q[3:0] : 4'd0;
  assign dig_cin = busy ? carry_q     : 1'b0;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
//
// Directed test of bcd_serial_add_ctrl with DIGITS=4. A behavioural BCD digit
// adder closes the loop on the dig_* ports. Inputs change and outputs are
// sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         ready, busy, done;
  logic [W-1:0] sum;
  logic         cout, err;
  logic [3:0]   dig_a, dig_b;
  logic         dig_cin;
  logic [3:0]   dig_s;
  logic         dig_cout;

  int tests_run    = 0;
  int tests_failed = 0;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .err      (err),
    .dig_a    (dig_a),
    .dig_b    (dig_b),
    .dig_cin  (dig_cin),
    .dig_s    (dig_s),
    .dig_cout (dig_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-digit BCD adder.
  logic [4:0] raw;
  always_comb begin
    raw = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, dig_cin};
    if (raw > 5'd9) begin
      dig_s    = 4'(raw + 5'd6);
      dig_cout = 1'b1;
    end else begin
      dig_s    = raw[3:0];
      dig_cout = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done=1, counting cycles; gives up after 20 cycles.
  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cycles++;
      if (done) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timeout, done never rose within 20 cycles", name);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    tests_run++;
    if ({ready, busy, done, sum, cout, err} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b sum=%h cout=%b err=%b, want 1 0 0 0000 0 0",
               ready, busy, done, sum, cout, err);
    end
    tests_run++;
    if ({dig_a, dig_b, dig_cin} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_dig: dig_a=%h dig_b=%h dig_cin=%b, want 0 0 0", dig_a, dig_b, dig_cin);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_add();
    int n;
    a = 16'h1234; b = 16'h5678; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if ({busy, ready, dig_a, dig_b, dig_cin} !== {1'b1, 1'b0, 4'h4, 4'h8, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_first_digit: busy=%b ready=%b dig_a=%h dig_b=%h cin=%b, want 1 0 4 8 0",
               busy, ready, dig_a, dig_b, dig_cin);
    end
    a = 16'h0000; b = 16'h0000;  // changing operands after acceptance must not matter
    wait_done("basic", n);
    tests_run++;
    if (n + 1 !== 5) begin
      tests_failed++;
      $display("FAIL basic_latency: done in cycle %0d, want 5", n + 1);
    end
    tests_run++;
    if ({sum, cout, err} !== {16'h6912, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_result: sum=%h cout=%b err=%b, want 6912 0 0", sum, cout, err);
    end
    tick();
    tests_run++;
    if ({done, ready, sum} !== {1'b0, 1'b1, 16'h6912}) begin
      tests_failed++;
      $display("FAIL basic_after: done=%b ready=%b sum=%h, want 0 1 6912", done, ready, sum);
    end
  endtask

  task automatic test_ripple_carry();
    int n;
    a = 16'h9999; b = 16'h0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests_run++;
    if ({dig_a, dig_b, dig_cin} !== {4'h9, 4'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL ripple_digit1: dig_a=%h dig_b=%h cin=%b, want 9 0 1", dig_a, dig_b, dig_cin);
    end
    wait_done("ripple", n);
    tests_run++;
    if (n !== 3) begin
      tests_failed++;
      $display("FAIL ripple_latency: done in cycle %0d, want 5", n + 2);
    end
    tests_run++;
    if ({sum, cout, err} !== {16'h0000, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL ripple_result: sum=%h cout=%b err=%b, want 0000 1 0", sum, cout, err);
    end
    tick();
  endtask

  task automatic test_bad_digit();
    a = 16'h12A4; b = 16'h0000; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if ({done, busy, err, sum, cout} !== {1'b1, 1'b0, 1'b1, 16'h0000, 1'b0}) begin
      tests_failed++;
      $display("FAIL bad_digit_result: done=%b busy=%b err=%b sum=%h cout=%b, want 1 0 1 0000 0",
               done, busy, err, sum, cout);
    end
    tests_run++;
    if ({dig_a, dig_b} !== 8'h00) begin
      tests_failed++;
      $display("FAIL bad_digit_dig: dig_a=%h dig_b=%h, want 0 0", dig_a, dig_b);
    end
    tick();
    tests_run++;
    if ({done, ready, err} !== {1'b0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL bad_digit_after: done=%b ready=%b err=%b, want 0 1 1", done, ready, err);
    end
  endtask

  task automatic test_start_while_busy();
    int n;
    a = 16'h0042; b = 16'h0013; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 16'h9999; b = 16'h9999; start = 1'b1;  // must be ignored
    tick();
    start = 1'b0;
    wait_done("busy_ignore", n);
    tests_run++;
    if (n !== 2) begin
      tests_failed++;
      $display("FAIL busy_latency: done in cycle %0d, want 5", n + 3);
    end
    tests_run++;
    if ({sum, cout, err} !== {16'h0055, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL busy_result: sum=%h cout=%b err=%b, want 0055 0 0", sum, cout, err);
    end
    // Start in the DONE cycle is accepted.
    a = 16'h0005; b = 16'h0005; start = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_reaccept: busy=%b, want 1", busy);
    end
    wait_done("five_plus_five", n);
    tests_run++;
    if ({sum, cout, err} !== {16'h0010, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL five_plus_five: sum=%h cout=%b err=%b, want 0010 0 0", sum, cout, err);
    end
    tick();
  endtask

  task automatic test_reset_mid_add();
    int seen_done;
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({ready, busy, done, sum, cout, err} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL abort_state: ready=%b busy=%b done=%b sum=%h cout=%b err=%b, want 1 0 0 0000 0 0",
               ready, busy, done, sum, cout, err);
    end
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: %0d done pulses, want 0", seen_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] op_a [3];
    logic [W-1:0] op_b [3];
    logic [W-1:0] exp_s[3];
    logic         exp_c[3];
    int n;
    op_a[0] = 16'h0999; op_b[0] = 16'h0001; exp_s[0] = 16'h1000; exp_c[0] = 1'b0;
    op_a[1] = 16'h4321; op_b[1] = 16'h1234; exp_s[1] = 16'h5555; exp_c[1] = 1'b0;
    op_a[2] = 16'h8765; op_b[2] = 16'h1235; exp_s[2] = 16'h0000; exp_c[2] = 1'b1;
    a = op_a[0]; b = op_b[0]; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_done("b2b", n);
      tests_run++;
      if (n !== 5) begin
        tests_failed++;
        $display("FAIL b2b_period[%0d]: %0d cycles, want 5", i, n);
      end
      tests_run++;
      if ({sum, cout, err, ready} !== {exp_s[i], exp_c[i], 1'b0, 1'b1}) begin
        tests_failed++;
        $display("FAIL b2b_result[%0d]: sum=%h cout=%b err=%b ready=%b, want %h %b 0 1",
                 i, sum, cout, err, ready, exp_s[i], exp_c[i]);
      end
      if (i < 2) begin
        a = op_a[i+1]; b = op_b[i+1];
      end
    end
    start = 1'b0;
    tick();
    tests_run++;
    if ({done, sum, cout} !== {1'b0, 16'h0000, 1'b1}) begin
      tests_failed++;
      $display("FAIL b2b_hold: done=%b sum=%h cout=%b, want 0 0000 1", done, sum, cout);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_ripple_carry();
    test_bad_digit();
    test_start_while_busy();
    test_reset_mid_add();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
